// File: rtl/lsu_hword_master.sv
// Load/store unit that turns byte, half-word and word CPU accesses into one or
// two cycles on a 16-bit half-word RAM port, with sign/zero extension of loads.
module lsu_hword_master #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_wenable,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic [31:0]           result_q;
  logic                  err_q;
  logic                  accept;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lsb[0];
      2'b10:   return lsb != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   return {{24{raw[7] & ~uns}}, raw[7:0]};
      2'b01:   return {{16{raw[15] & ~uns}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= req_addr;
        write_q  <= req_write;
        size_q   <= req_size;
        uns_q    <= req_unsigned;
        wdata_q  <= req_wdata;
        err_q    <= misaligned(req_size, req_addr[1:0]);
        result_q <= '0;
      end
      // Low half is captured leaving LO, high half leaving HI.
      if (state == LO) result_q[15:0]  <= mem_rdata;
      if (state == HI) result_q[31:16] <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wenable = 2'b00;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = misaligned(req_size, req_addr[1:0]) ? RESP : LO;
      end
      LO: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q[15:0];
        if (write_q) mem_wenable = (size_q == 2'b00) ? 2'b01 : 2'b11;
        state_nxt = (size_q == 2'b10) ? HI : RESP;
      end
      HI: begin
        mem_addr  = addr_q + ADDR_WIDTH'(2);
        mem_wdata = wdata_q[31:16];
        if (write_q) mem_wenable = 2'b11;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A store cut short by reset must not write at the reset edge.
    if (rst) mem_wenable = 2'b00;
  end

  assign resp_error = err_q;
  assign resp_rdata = (write_q || err_q) ? 32'h0 : extend(result_q, size_q, uns_q);

endmodule

// File: tb/tb_lsu_hword_master.sv
// Randomized bench for lsu_hword_master: a byte-array reference memory predicts
// every cycle of each transaction, plus literal checks of hand-worked cases.
module tb_lsu_hword_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wenable;
  logic [15:0] mem_rdata;

  lsu_hword_master #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wenable(mem_wenable), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical RAM driven only by the DUT port.
  logic [7:0] ram [65536];
  bit         filled;
  assign mem_rdata = {ram[mem_addr + 16'd1], ram[mem_addr]};

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'((i * 37 + 11) ^ (i >> 8));
      filled <= 1'b1;
    end else begin
      if (mem_wenable[0]) ram[mem_addr]          <= mem_wdata[7:0];
      if (mem_wenable[1]) ram[mem_addr + 16'd1]  <= mem_wdata[15:8];
    end
  end

  // Reference memory and per-cycle expectations.
  logic [7:0]  ref_mem [65536];
  logic        e_ready, e_valid, e_err, chk_en, chk_resp;
  logic [31:0] e_rdata, held_rdata;
  logic        held_err;
  logic [15:0] e_addr, e_wdata;
  logic [1:0]  e_we;
  int          e_kind;

  int          n_total, n_fail;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [15:0] lo_addr, lo_wdata, hi_addr, hi_wdata;
  logic [1:0]  lo_we;

  string       lit_name;
  logic [31:0] lit_act, lit_exp;
  int          lit_seq, lit_done;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("resp_valid", 32'(resp_valid), 32'(e_valid));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("mem_wenable", 32'(mem_wenable), 32'(e_we));
      if (chk_resp) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_error", 32'(resp_error), 32'(e_err));
      end
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_error;
      end
      if (e_kind == 1) begin
        lo_addr = mem_addr; lo_we = mem_wenable; lo_wdata = mem_wdata;
      end
      if (e_kind == 2) begin
        hi_addr = mem_addr; hi_wdata = mem_wdata;
      end
    end
    if (lit_seq != lit_done) begin
      chk(lit_name, lit_act, lit_exp);
      lit_done = lit_seq;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_ready = 1'b1; e_valid = 1'b0; e_rdata = held_rdata; e_err = held_err;
    e_addr = '0; e_wdata = '0; e_we = 2'b00; e_kind = 0; chk_resp = 1'b1;
  endtask

  task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
    lit_name = n; lit_act = act; lit_exp = exp; lit_seq++;
    step();
  endtask

  task automatic junk();
    req_valid    = 1'($urandom_range(0, 1));
    req_addr     = 16'($urandom);
    req_write    = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_wdata    = $urandom;
  endtask

  // One full transaction; expectations come from the access rules, not the RTL.
  task automatic xact(input logic [15:0] a, input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd, input bit rst_in_hi);
    logic        err;
    logic [31:0] v, r;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    v = {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
    req_valid = 1'b1; req_addr = a; req_write = w; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    step();
    junk();
    e_ready = 1'b0; e_addr = '0; e_wdata = '0; e_we = 2'b00;
    if (err) begin
      e_valid = 1'b1; e_rdata = 32'h0; e_err = 1'b1; chk_resp = 1'b1; e_kind = 3;
      held_rdata = 32'h0; held_err = 1'b1;
      step();
    end else begin
      e_valid = 1'b0; chk_resp = 1'b0; e_kind = 1;
      e_addr = a; e_wdata = wd[15:0];
      e_we = !w ? 2'b00 : (sz == 2'd0 ? 2'b01 : 2'b11);
      step();
      junk();
      if (w) begin
        ref_mem[a] = wd[7:0];
        if (sz != 2'd0) ref_mem[a + 16'd1] = wd[15:8];
      end
      if (sz == 2'd2) begin
        e_kind = 2; e_addr = a + 16'd2; e_wdata = wd[31:16];
        e_we = (w && !rst_in_hi) ? 2'b11 : 2'b00;
        if (rst_in_hi) rst = 1'b1;
        step();
        junk();
        if (rst_in_hi) begin
          rst = 1'b0; req_valid = 1'b0;
          held_rdata = 32'h0; held_err = 1'b0;
          set_idle();
          return;
        end
        if (w) begin
          ref_mem[a + 16'd2] = wd[23:16];
          ref_mem[a + 16'd3] = wd[31:24];
        end
      end
      case (sz)
        2'd0:    r = u ? 32'(v[7:0])  : 32'($signed(v[7:0]));
        2'd1:    r = u ? 32'(v[15:0]) : 32'($signed(v[15:0]));
        default: r = v;
      endcase
      if (w) r = 32'h0;
      e_kind = 3; e_addr = '0; e_wdata = '0; e_we = 2'b00;
      e_valid = 1'b1; e_rdata = r; e_err = 1'b0; chk_resp = 1'b1;
      held_rdata = r; held_err = 1'b0;
      step();
    end
    req_valid = 1'b0;
    set_idle();
  endtask

  initial begin
    logic [15:0] a;
    logic [1:0]  sz;
    n_total = 0; n_fail = 0; lit_seq = 0; lit_done = 0;
    chk_en = 1'b0; held_rdata = 32'h0; held_err = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
    set_idle();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    xact(16'h0010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    lit("lit_lo_addr", 32'(lo_addr), 32'h0010);
    lit("lit_lo_we", 32'(lo_we), 32'h3);
    lit("lit_lo_wdata", 32'(lo_wdata), 32'hBEEF);
    lit("lit_hi_addr", 32'(hi_addr), 32'h0012);
    lit("lit_hi_wdata", 32'(hi_wdata), 32'hDEAD);
    xact(16'h0010, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    lit("lit_word_load", last_rdata, 32'hDEADBEEF);
    lit("lit_word_err", 32'(last_err), 32'h0);

    xact(16'h0020, 1'b1, 2'd1, 1'b0, 32'h000080F0, 1'b0);
    xact(16'h0021, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    lit("lit_sbyte", last_rdata, 32'hFFFFFF80);
    xact(16'h0021, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0);
    lit("lit_ubyte", last_rdata, 32'h00000080);
    xact(16'h0020, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
    lit("lit_shalf", last_rdata, 32'hFFFF80F0);

    xact(16'h0030, 1'b1, 2'd0, 1'b0, 32'h0000005C, 1'b0);
    xact(16'h0031, 1'b1, 2'd0, 1'b0, 32'h000000AB, 1'b0);
    lit("lit_bst_addr", 32'(lo_addr), 32'h0031);
    lit("lit_bst_we", 32'(lo_we), 32'h1);
    lit("lit_bst_wdata", 32'(lo_wdata[7:0]), 32'hAB);
    xact(16'h0030, 1'b0, 2'd1, 1'b1, 32'h0, 1'b0);
    lit("lit_bst_readback", last_rdata, 32'h0000AB5C);

    xact(16'h0003, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
    lit("lit_err_half", 32'(last_err), 32'h1);
    xact(16'h0006, 1'b1, 2'd2, 1'b0, 32'h12345678, 1'b0);
    lit("lit_err_word", 32'(last_err), 32'h1);
    xact(16'h0008, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0);
    lit("lit_err_size", 32'(last_err), 32'h1);

    xact(16'hFFFC, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    lit("lit_wrap_hi", 32'(hi_addr), 32'hFFFE);
    xact(16'hFFFE, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);
    lit("lit_wrap_err", 32'(last_err), 32'h1);

    xact(16'h0040, 1'b1, 2'd2, 1'b0, 32'h11223344, 1'b0);
    xact(16'h0040, 1'b1, 2'd2, 1'b0, 32'hAABBCCDD, 1'b1);
    xact(16'h0040, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    lit("lit_abort_store", last_rdata, 32'h1122CCDD);

    for (int t = 0; t < 400; t++) begin
      a  = ($urandom_range(0, 9) < 7) ? {8'h00, 8'($urandom)} : {12'hFFF, 4'($urandom)};
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~16'(32'(sz) * 32'(sz) + 32'(sz[1]) * 0);
      xact(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom,
           (sz == 2'd2 && $urandom_range(0, 19) == 0));
      for (int k = $urandom_range(0, 2); k > 0; k--) step();
    end

    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_hword_master.md
LSU_HWORD_MASTER -- requirements
Module: lsu_hword_master

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, byte-address width of the memory port; shall be at least 3.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high; one clock only, no other clock or reset.
REQ-004 req_valid  input  1  CPU access request valid.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_addr  input  ADDR_WIDTH  byte address of the access.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half-word, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 resp_error  output  1  qualified by resp_valid; misaligned or illegal access.
REQ-014 mem_addr  output  ADDR_WIDTH  byte address to the half-word RAM read/write port.
REQ-015 mem_wdata  output  16  write data to the RAM.
REQ-016 mem_wenable  output  2  per-byte write enables; bit0 = wdata[7:0], bit1 = wdata[15:8].
REQ-017 mem_rdata  input  16  RAM read data, combinational from mem_addr; bits [7:0] are the byte at mem_addr.

Function
REQ-018 States: IDLE, LO, HI, RESP; 2-bit state register.
REQ-019 IDLE: req_ready=1. On req_valid the block latches addr, write, size, unsigned and wdata. Aligned, legal requests go to LO. Misaligned or illegal requests go to RESP with an error flag and make no memory access.
REQ-020 Misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11 is always illegal.
REQ-021 req_ready=0 in LO, HI and RESP; req_valid there is ignored.
REQ-022 LO: mem_addr = latched addr.
  - Byte: mem_wenable=01 if store, else 00.
  - Half or word: mem_wenable=11 if store, else 00.
  - mem_wdata = wdata[15:0].
  - Word goes to HI; byte or half goes to RESP.
REQ-023 HI (word only): mem_addr = latched addr + 2, modulo 2^ADDR_WIDTH (wraps at top of space). mem_wenable=11 if store; mem_wdata = wdata[31:16]; next state RESP.
REQ-024 Load capture: at the clock edge leaving LO, mem_rdata is registered into bits [15:0] of the result; at the edge leaving HI, into bits [31:16].
REQ-025 Load extension: byte extends from bit 7; half-word from bit 15; word is unmodified.
REQ-026 RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure.
REQ-027 Latency from the accept edge (cycle N): error -> resp_valid in N+1; byte or half -> N+2; word -> N+3.
REQ-028 Back-to-back: a new request can be accepted in the cycle after RESP. Sustained throughput: one byte/half access per 3 cycles, one word per 4.
REQ-029 Outside LO and HI: mem_addr=0, mem_wdata=0, mem_wenable=00.
REQ-030 resp_rdata and resp_error are held stable from RESP until the next accept.

Reset
REQ-031 On rst high at a clock edge:
  - state goes to IDLE;
  - the result register, resp_error and all latched request fields clear to 0.
REQ-032 mem_wenable shall be 00 combinationally whenever rst=1, so a store interrupted mid-operation writes nothing at that edge. A word store aborted after LO leaves only the low half written.
REQ-033 Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_addr=0, mem_wdata=0, mem_wenable=00.

Verification
REQ-034 Word store then load. Store addr 0x0010, wdata 0xDEADBEEF. Then expect:
  - LO cycle: mem_addr 0x0010, wenable 11, wdata 0xBEEF.
  - HI cycle: mem_addr 0x0012, wdata 0xDEAD.
  - Word load from 0x0010 returns 0xDEADBEEF at N+3, resp_error=0.
REQ-035 Byte load, RAM holds half-word 0x80F0 at 0x0020.
  - Signed byte load of 0x0021 -> 0xFFFFFF80.
  - Unsigned byte load of 0x0021 -> 0x00000080.
  - Signed half load of 0x0020 -> 0xFFFF80F0.
REQ-036 Byte store to 0x0031, wdata 0x000000AB. Expect mem_addr 0x0031, wenable 01, wdata[7:0]=0xAB. A later load of 0x0030 shows the low byte unchanged.
REQ-037 Error paths. Each of the following gets resp_valid with resp_error=1 at N+1 and no mem_wenable activity:
  - half load at 0x0003;
  - word store at 0x0006;
  - size=11.
REQ-038 Wrap and reset.
  - ADDR_WIDTH=16 word load at 0xFFFC: HI drives mem_addr 0xFFFE.
  - Word store at 0xFFFE is rejected as misaligned.
  - rst asserted during HI of a word store: mem_wenable=00 at that edge; next cycle req_ready=1, resp_valid=0.
